vdp_host_arbiter: RTL and testbench
===================================

# vdp_host_arbiter

Arbitrates the VDP's single 16-bit host register bus between two requesters: the management SoC over the Wishbone slave port, and a debug host driven over logic-analyzer bits with a 4-phase handshake. It sits in the user project, between the wrapper-level Wishbone/LA signals and the VDP core's host port. It sequences each access: grant, issue, wait for the read latency, respond. It also protects both masters from a hung VDP with a timeout.

## Interface
- `ADDR_W`, 8: VDP register address width (word address).
- `RD_LAT`, 2: cycles from accepted read to valid `vdp_dat_i`, range 1..7.
- `WB_BASE`, 8'h30: required value of `wbs_adr_i[31:24]`.
- `TIMEOUT`, 15: maximum `ISSUE` cycles waiting on `vdp_ready_i`, range 1..255.

Ports:
- `wb_clk_i` in 1: the only clock.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone classic control.
- `wbs_sel_i` in 4: byte enables; only `[1:0]` are used.
- `wbs_adr_i` in 32: byte address; the word address is `[ADDR_W+1:2]`.
- `wbs_dat_i` in 32: write data; only `[15:0]` are used.
- `wbs_ack_o` out 1: one-cycle acknowledge.
- `wbs_dat_o` out 32: read data, `{16'h0, data}`.
- `la_req_i` in 1: debug request level.
- `la_we_i` in 1: debug write when high, read when low.
- `la_adr_i` in ADDR_W: debug address.
- `la_dat_i` in 16: debug write data.
- `la_done_o` out 1: debug completion level.
- `la_dat_o` out 16: debug read data.
- `err_o` out 1: sticky timeout flag.
- `vdp_cs_o` out 1: host bus access request.
- `vdp_we_o` out 1: host bus write.
- `vdp_be_o` out 2: host bus byte enables.
- `vdp_adr_o` out ADDR_W: host bus address.
- `vdp_dat_o` out 16: host bus write data.
- `vdp_ready_i` in 1: the VDP accepts the access on a cycle where `vdp_cs_o & vdp_ready_i`.
- `vdp_dat_i` in 16: host bus read data.

## Operation
- **Request definitions:**
  - WB request: `cyc & stb & !ack_pending`.
  - LA request: `la_req_i & !la_done_o`. `la_req_i` is synchronised through a 2-flop stage before use; the other `la_*` inputs are sampled only after the synced request is seen.
- **Address decode:** a WB request with `wbs_adr_i[31:24] != WB_BASE` never reaches the VDP. It is acked on the next cycle with `wbs_dat_o = 0`.
- **Empty write enables:** a WB write with `sel[1:0] == 0` is acked with no bus cycle.
- **Arbitration, in `IDLE` only:**
  - A single requester is granted.
  - If both request, grant goes to the one not granted last (round-robin flop `last_lA`, reset 0, so WB wins the first tie).
  - The grant is held until `RESP` completes.
- **States:**
  - `IDLE`: on a grant, latch address, data, `we` and `be` (LA: `be = 2'b11`), then go to `ISSUE`.
  - `ISSUE`: `vdp_cs_o = 1` with the latched fields.
    - If `vdp_ready_i`: go to `RESP` for a write, `WAIT` for a read.
    - If `ready` stays low for `TIMEOUT` cycles: set `err_o`, load data 16'hFFFF, go to `RESP`.
  - `WAIT`: count `RD_LAT-1` cycles down to 0, capture `vdp_dat_i` on the last, go to `RESP`.
  - `RESP`:
    - WB grant: `wbs_ack_o = 1` for exactly one cycle, `wbs_dat_o` valid in the same cycle.
    - LA grant: `la_dat_o` updates and `la_done_o` rises; the FSM then stays in `RESP` until the synced `la_req_i` is low, then `la_done_o` falls.
    - Exit to `IDLE` in either case.
- **Bus outputs:** `vdp_cs_o` is high only in `ISSUE`. `vdp_we_o`, `vdp_adr_o`, `vdp_dat_o` and `vdp_be_o` are held stable for all of `ISSUE`.
- **Error flag:** `err_o` clears only on reset.
- **WB abandon:** if the master drops `cyc` mid-transaction, the VDP access still completes and the ack is suppressed.

## Timing
- **Reset values:** all outputs 0; FSM in `IDLE`; `last_lA` = 0.
- **WB write, ready high:** request seen at cycle 0, `cs` at 1, ack at 2. Two cycles to ack.
- **WB read:** `cs` at 1, data captured at cycle `1+RD_LAT`, ack at `2+RD_LAT` (4 for the default).
- **Stall:** each `ready`-low cycle in `ISSUE` adds one cycle of latency.
- **Decode miss:** ack at cycle 1.
- **LA access:** add 2 cycles of synchroniser latency before the grant; `done` falls 3 cycles after `la_req_i` falls.
- **Back-to-back:** at least one `IDLE` cycle between accesses.
- **Reset mid-access:** `cs`, `ack` and `done` drop immediately, with no completion.

## Structure
- Package `vdp_host_pkg`:
  - state enum `IDLE`/`ISSUE`/`WAIT`/`RESP`;
  - `WB_BASE` default;
  - `TIMEOUT_DATA = 16'hFFFF`.
- Sub-module `vdp_sync2`: a 2-flop synchroniser for `la_req_i`, with reset value 0.

## Test plan
- **WB write:** adr 0x3000_0010, data 0x1234, sel 4'b0011, ready high → `vdp_adr_o` = 4, `vdp_dat_o` = 0x1234, `be` = 2'b11; ack 2 cycles after stb.
- **WB read:** adr 0x3000_0008, `vdp_dat_i` = 0xBEEF at the capture cycle → `wbs_dat_o` = 0x0000BEEF; ack 4 cycles after stb.
- **Simultaneous WB and LA requests, repeated 4 times:** grants alternate WB, LA, WB, LA; no `cs` overlap.
- **Timeout:** ready held low, WB read → ack exactly 1+TIMEOUT+1 cycles after stb; data 0x0000FFFF; `err_o` = 1 and stays 1.
- **Decode miss:** adr 0x2000_0000 → ack at cycle 1, data 0, `vdp_cs_o` never high.
- **Reset mid-access:** `wb_rst_i` asserted during `WAIT` → all outputs 0 asynchronously; the next WB request completes normally.

Source files
------------

// File: rtl/vdp_host_pkg.sv
// Shared state encoding and constants for the VDP host-bus arbiter.
package vdp_host_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [7:0]  WB_BASE_DEF  = 8'h30;
  localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;
endpackage

// File: rtl/vdp_host_arbiter_sync2.sv
// Two-flop synchroniser for the asynchronous debug request level.
module vdp_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/vdp_host_arbiter.sv
// Wishbone / LA-handshake arbiter in front of the VDP host register bus.
module vdp_host_arbiter
  import vdp_host_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned RD_LAT  = 2,
  parameter logic [7:0]  WB_BASE = WB_BASE_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              la_req_i,
  input  logic              la_we_i,
  input  logic [ADDR_W-1:0] la_adr_i,
  input  logic [15:0]       la_dat_i,
  output logic              la_done_o,
  output logic [15:0]       la_dat_o,
  output logic              err_o,
  output logic              vdp_cs_o,
  output logic              vdp_we_o,
  output logic [1:0]        vdp_be_o,
  output logic [ADDR_W-1:0] vdp_adr_o,
  output logic [15:0]       vdp_dat_o,
  input  logic              vdp_ready_i,
  input  logic [15:0]       vdp_dat_i
);
  localparam logic [2:0] LAT_LD = 3'(RD_LAT - 1);
  localparam logic [7:0] TO_MAX = 8'(TIMEOUT);

  state_t      state;
  logic        req_s;
  logic        gnt_la;
  logic        last_la;
  logic        wb_abort;
  logic [2:0]  lat_cnt;
  logic [7:0]  to_cnt;
  logic        wb_req;
  logic        la_req;
  logic        pick_wb;
  logic        wb_hit;
  logic        wb_skip;
  logic        fin_to;
  logic        fin;
  logic        abort_now;
  logic [15:0] fin_dat;
  logic        unused;

  vdp_sync2 u_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (la_req_i),
    .q   (req_s)
  );

  assign wb_req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign la_req    = req_s & ~la_done_o;
  assign pick_wb   = wb_req & (~la_req | last_la);
  assign wb_hit    = wbs_adr_i[31:24] == WB_BASE;
  assign wb_skip   = wbs_we_i & (wbs_sel_i[1:0] == 2'b00);
  assign fin_to    = (state == ISSUE) & ~vdp_ready_i
                   & (to_cnt == TO_MAX);
  assign fin       = fin_to
                   | ((state == ISSUE) & vdp_ready_i & vdp_we_o)
                   | ((state == WAIT) & (lat_cnt == 3'd0));
  assign fin_dat   = fin_to ? TIMEOUT_DATA :
                     (state == WAIT) ? vdp_dat_i : vdp_dat_o;
  assign abort_now = wb_abort | ~wbs_cyc_i;
  assign unused    = ^{wbs_sel_i[3:2], wbs_adr_i[23:ADDR_W+2],
                       wbs_adr_i[1:0], wbs_dat_i[31:16]};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      gnt_la    <= 1'b0;
      last_la   <= 1'b0;
      wb_abort  <= 1'b0;
      lat_cnt   <= 3'd0;
      to_cnt    <= 8'd0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
      la_done_o <= 1'b0;
      la_dat_o  <= 16'h0;
      err_o     <= 1'b0;
      vdp_cs_o  <= 1'b0;
      vdp_we_o  <= 1'b0;
      vdp_be_o  <= 2'b00;
      vdp_adr_o <= '0;
      vdp_dat_o <= 16'h0;
    end else begin
      unique case (state)
        IDLE: begin
          wbs_ack_o <= 1'b0;
          if (pick_wb) begin
            last_la <= 1'b0;
            if (!wb_hit || wb_skip) begin
              // Served locally: ack next cycle, bus untouched
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= 32'h0;
            end else begin
              gnt_la    <= 1'b0;
              wb_abort  <= 1'b0;
              vdp_we_o  <= wbs_we_i;
              vdp_be_o  <= wbs_sel_i[1:0];
              vdp_adr_o <= wbs_adr_i[ADDR_W+1:2];
              vdp_dat_o <= wbs_dat_i[15:0];
              vdp_cs_o  <= 1'b1;
              to_cnt    <= 8'd0;
              state     <= ISSUE;
            end
          end else if (la_req) begin
            last_la   <= 1'b1;
            gnt_la    <= 1'b1;
            wb_abort  <= 1'b0;
            vdp_we_o  <= la_we_i;
            vdp_be_o  <= 2'b11;
            vdp_adr_o <= la_adr_i;
            vdp_dat_o <= la_dat_i;
            vdp_cs_o  <= 1'b1;
            to_cnt    <= 8'd0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!gnt_la && !wbs_cyc_i) wb_abort <= 1'b1;
          if (vdp_ready_i) begin
            vdp_cs_o <= 1'b0;
            lat_cnt  <= LAT_LD;
            state    <= WAIT;
          end else if (fin_to) begin
            err_o <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        WAIT: begin
          if (!gnt_la && !wbs_cyc_i) wb_abort <= 1'b1;
          if (lat_cnt != 3'd0) lat_cnt <= lat_cnt - 3'd1;
        end
        RESP: begin
          if (!gnt_la) begin
            wbs_ack_o <= 1'b0;
            state     <= IDLE;
          end else if (!req_s) begin
            la_done_o <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
      // Completion overrides the per-state next state
      if (fin) begin
        state    <= RESP;
        vdp_cs_o <= 1'b0;
        if (gnt_la) begin
          la_dat_o  <= fin_dat;
          la_done_o <= 1'b1;
        end else if (!abort_now) begin
          wbs_ack_o <= 1'b1;
          wbs_dat_o <= {16'h0, fin_dat};
        end
      end
    end
  end
endmodule

// File: tb/tb_vdp_host_arbiter.sv
// Self-checking bench: directed and random host accesses against a VDP model.
module tb_vdp_host_arbiter;
  localparam int RD_LAT  = 2;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic       we;
    logic [1:0] be;
    logic [7:0] adr;
    logic [15:0] dat;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic        la_req = 1'b0, la_we = 1'b0;
  logic [7:0]  la_adr = 8'h0;
  logic [15:0] la_wdat = 16'h0;
  logic        la_done;
  logic [15:0] la_rdat;
  logic        err, cs, vwe;
  logic [1:0]  vbe;
  logic [7:0]  vadr;
  logic [15:0] vwdat;
  logic        vready;
  logic [15:0] vrdat;

  int          total = 0;
  int          bad = 0;
  int          stall_cfg = 0;
  int          cs_cycles = 0;
  logic [15:0] ref_mem [256];
  logic [15:0] vmem [256];
  acc_t        accq [$];

  always #5 clk = ~clk;

  vdp_host_arbiter #(
    .ADDR_W(8), .RD_LAT(RD_LAT), .WB_BASE(8'h30), .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .la_req_i(la_req), .la_we_i(la_we), .la_adr_i(la_adr),
    .la_dat_i(la_wdat), .la_done_o(la_done), .la_dat_o(la_rdat),
    .err_o(err), .vdp_cs_o(cs), .vdp_we_o(vwe), .vdp_be_o(vbe),
    .vdp_adr_o(vadr), .vdp_dat_o(vwdat),
    .vdp_ready_i(vready), .vdp_dat_i(vrdat)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // VDP host-port model: stalls, accepts, returns read data RD_LAT later
  initial begin
    acc_t cur, first;
    logic prev_cs, acc_prev;
    int   stall_left, rd_cnt;
    logic [7:0] rd_adr;
    prev_cs = 0; acc_prev = 0; stall_left = 0; rd_cnt = 0; rd_adr = 0;
    vready = 1'b0;
    vrdat = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (rd_cnt > 0) begin
        rd_cnt--;
        vrdat = (rd_cnt == 0) ? vmem[rd_adr] : 16'hDEAD;
      end else begin
        vrdat = 16'hDEAD;
      end
      if (acc_prev) chk("idle_gap", cs, 0);
      acc_prev = 0;
      if (cs) begin
        cs_cycles++;
        cur = {vwe, vbe, vadr, vwdat};
        if (!prev_cs) begin
          stall_left = stall_cfg;
          first = cur;
        end else begin
          chk("cs_stable", cur, first);
        end
        if (stall_left == 0) begin
          vready = 1'b1;
          acc_prev = 1;
          accq.push_back(cur);
          if (cur.we) begin
            if (cur.be[0]) vmem[cur.adr][7:0] = cur.dat[7:0];
            if (cur.be[1]) vmem[cur.adr][15:8] = cur.dat[15:8];
          end else begin
            rd_cnt = RD_LAT;
            rd_adr = cur.adr;
          end
        end else begin
          vready = 1'b0;
          stall_left--;
        end
      end else begin
        vready = 1'b0;
      end
      prev_cs = cs;
    end
  end

  task automatic wb_xfer(input logic w, input logic [31:0] a,
                         input logic [15:0] d, input logic [3:0] s,
                         output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; sel = s;
    wdat = {16'($urandom), d};
    lat = -1;
    rd = '0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ack) begin
        lat = n;
        rd = rdat;
        break;
      end
    end
    @(posedge clk); #1;
    cyc = 0; stb = 0;
    @(negedge clk);
    chk("ack_one_cycle", ack, 0);
  endtask

  task automatic la_xfer(input logic w, input logic [7:0] a,
                         input logic [15:0] d, output logic [15:0] rd,
                         output int lat, output int fall);
    @(posedge clk); #1;
    la_we = w; la_adr = a; la_wdat = d; la_req = 1;
    lat = -1; fall = -1; rd = '0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (la_done) begin
        lat = n;
        rd = la_rdat;
        break;
      end
    end
    @(posedge clk); #1;
    la_req = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!la_done) begin
        fall = n;
        break;
      end
    end
  endtask

  task automatic chk_acc(input int n, input acc_t e);
    acc_t a;
    chk("acc_count", accq.size(), n);
    if (accq.size() > 0) begin
      a = accq.pop_front();
      if (n > 0) begin
        chk("acc_we", a.we, e.we);
        chk("acc_adr", a.adr, e.adr);
        chk("acc_be", a.be, e.be);
        if (e.we) chk("acc_dat", a.dat, e.dat);
      end
    end
  endtask

  task automatic wb_op(input logic w, input logic [31:0] a32,
                       input logic [15:0] d, input logic [3:0] s,
                       input int st, output logic [31:0] rd,
                       output int lat);
    logic       hit;
    logic [7:0] a;
    int         elat, en;
    hit = a32[31:24] == 8'h30;
    a = a32[9:2];
    if (!hit || (w && s[1:0] == 2'b00)) begin
      elat = 1;
      en = 0;
    end else begin
      elat = w ? 2 + st : 2 + RD_LAT + st;
      en = 1;
    end
    stall_cfg = st;
    wb_xfer(w, a32, d, s, rd, lat);
    chk("wb_latency", lat, elat);
    if (!w) chk("wb_rdata", rd, hit ? {16'h0, ref_mem[a]} : 32'h0);
    chk_acc(en, {w, s[1:0], a, d});
    if (hit && w) begin
      if (s[0]) ref_mem[a][7:0] = d[7:0];
      if (s[1]) ref_mem[a][15:8] = d[15:8];
    end
  endtask

  task automatic la_op(input logic w, input logic [7:0] a,
                       input logic [15:0] d, input int st);
    logic [15:0] rd;
    int lat, fall;
    stall_cfg = st;
    la_xfer(w, a, d, rd, lat, fall);
    chk("la_latency", lat, w ? 4 + st : 4 + RD_LAT + st);
    chk("la_done_fall", fall, 3);
    if (!w) chk("la_rdata", rd, ref_mem[a]);
    chk_acc(1, {w, 2'b11, a, d});
    if (w) ref_mem[a] = d;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_ctl"}, {ack, cs, la_done, err, vwe, vbe}, 0);
    chk({p, "_wbdat"}, rdat, 0);
    chk({p, "_ladat"}, la_rdat, 0);
    chk({p, "_vadr"}, vadr, 0);
    chk({p, "_vdat"}, vwdat, 0);
  endtask

  initial begin
    logic [31:0] rd, r1, r3;
    logic [15:0] r2, r4;
    int lat, l1, l2, f2, snap;
    acc_t a;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 16'h0;
      vmem[i] = 16'h0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 0;
    @(posedge clk); #1;
    chk_zero("post_reset");

    wb_op(1, 32'h3000_0010, 16'h1234, 4'b0011, 0, rd, lat);
    chk("wr_lat_lit", lat, 2);
    chk("wr_vmem", vmem[4], 16'h1234);

    vmem[2] = 16'hBEEF;
    ref_mem[2] = 16'hBEEF;
    wb_op(0, 32'h3000_0008, 16'h0, 4'b0011, 0, rd, lat);
    chk("rd_data_lit", rd, 32'h0000_BEEF);
    chk("rd_lat_lit", lat, 4);

    snap = cs_cycles;
    wb_op(0, 32'h2000_0000, 16'h0, 4'b0011, 0, rd, lat);
    chk("miss_no_cs", cs_cycles, snap);
    wb_op(1, 32'h3000_0014, 16'h5555, 4'b1100, 0, rd, lat);

    la_op(1, 8'h77, 16'hCAFE, 1);
    la_op(0, 8'h77, 16'h0, 0);

    // Contended grants after an LA access: WB, LA, WB, LA
    la_op(1, 8'h60, 16'h0F0F, 0);
    stall_cfg = 0;
    fork
      begin
        repeat (2) @(posedge clk);
        wb_xfer(1, 32'h3000_0100, 16'h1111, 4'h3, r1, l1);
        wb_xfer(1, 32'h3000_0104, 16'h3333, 4'h3, r3, l1);
      end
      begin
        la_xfer(1, 8'h50, 16'h2222, r2, l2, f2);
        la_xfer(1, 8'h51, 16'h4444, r4, l2, f2);
      end
    join
    chk("rr_count", accq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_adr [4];
      exp_adr[0] = 8'h40; exp_adr[1] = 8'h50;
      exp_adr[2] = 8'h41; exp_adr[3] = 8'h51;
      if (accq.size() > 0) begin
        a = accq.pop_front();
        chk("rr_order", a.adr, exp_adr[i]);
      end
    end
    ref_mem[8'h40] = 16'h1111; ref_mem[8'h41] = 16'h3333;
    ref_mem[8'h50] = 16'h2222; ref_mem[8'h51] = 16'h4444;

    for (int i = 0; i < 24; i++) begin
      int k, st;
      logic [7:0] base, aw;
      k = $urandom_range(0, 3);
      st = $urandom_range(0, 3);
      aw = 8'($urandom_range(0, 15));
      if (k == 3) begin
        la_op(1'($urandom), aw, 16'($urandom), st);
      end else begin
        base = 8'h30;
        if ($urandom_range(0, 3) == 0) begin
          base = 8'($urandom_range(0, 255));
          if (base == 8'h30) base = 8'h31;
        end
        wb_op(1'($urandom), {base, 14'($urandom), aw, 2'b00},
              16'($urandom), 4'($urandom), st, rd, lat);
      end
    end

    stall_cfg = 1000;
    wb_xfer(0, 32'h3000_0020, 16'h0, 4'h3, rd, lat);
    chk("to_latency", lat, TIMEOUT + 2);
    chk("to_data", rd, 32'h0000_FFFF);
    chk("to_err", err, 1);
    chk_acc(0, '0);
    wb_op(1, 32'h3000_0024, 16'hA5A5, 4'h3, 0, rd, lat);
    chk("err_sticky", err, 1);

    // Reset while a read sits in WAIT
    stall_cfg = 0;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = 32'h3000_0030; sel = 4'h3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_accepted", accq.size(), 1);
    chk("mid_cs_low", cs, 0);
    #2 rst = 1;
    #1;
    chk_zero("async_rst");
    cyc = 0; stb = 0;
    accq.delete();
    @(posedge clk); #1;
    rst = 0;
    wb_op(1, 32'h3000_0034, 16'h9876, 4'h3, 0, rd, lat);
    chk("post_rst_wr_lat", lat, 2);
    wb_op(0, 32'h3000_0034, 16'h0, 4'h3, 0, rd, lat);
    chk("post_rst_rd", rd, 32'h0000_9876);
    chk("post_rst_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
